// File: rtl/mem_lsu.sv
// Load/store unit with byte/halfword/word accesses, read-modify-write sub-word stores
// and sign/zero-extended loads. Define LSU_ALIGN_CHECK_EN to fault misaligned requests.
module mem_lsu #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [2:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_we,
    input  logic [31:0]       mem_dout,
    output logic [1:0]        dbg_state
);

    // Handshake: a request is taken on any rising edge where the unit is idle
    // (busy=0) and req=1; done pulses for exactly one cycle when it completes.

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic        bad_align;
    logic        accept;
    logic        op_store;
    logic        op_q_store;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merge_val;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr[31:ADDR_W];

    assign accept     = (state == IDLE) && req;
    assign op_store   = op[2] & (op[1] | op[0]);
    assign op_q_store = op_q[2] & (op_q[1] | op_q[0]);

`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        bad_align = 1'b0;
        case (op)
            OP_LW, OP_SW:         bad_align = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: bad_align = addr[0];
            default:              bad_align = 1'b0;
        endcase
    end
`else
    assign bad_align = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad_align)         state_nxt = DONE;
                    else if (op == OP_SW)  state_nxt = WR;
                    else                   state_nxt = RD;
                end
            end
            RD:      state_nxt = op_q_store ? WR : DONE;
            WR:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Halfword lane uses off_q[1] only, so unchecked halfword accesses truncate addr[0].
    always_comb begin
        lane_b = mem_dout[{off_q, 3'b000} +: 8];
        lane_h = off_q[1] ? mem_dout[31:16] : mem_dout[15:0];
        case (op_q)
            OP_LH:   load_val = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_val = {16'h0000, lane_h};
            OP_LB:   load_val = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_val = {24'h000000, lane_b};
            default: load_val = mem_dout;
        endcase
    end

    // mem_din still holds the latched store data while in RD.
    always_comb begin
        merge_val = mem_dout;
        if (op_q == OP_SB)
            merge_val[{off_q, 3'b000} +: 8] = mem_din[7:0];
        else if (op_q == OP_SH) begin
            if (off_q[1]) merge_val[31:16] = mem_din[15:0];
            else          merge_val[15:0]  = mem_din[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= OP_LW;
            off_q    <= 2'b00;
            rdata    <= 32'h0;
            misalign <= 1'b0;
            mem_addr <= '0;
            mem_din  <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q     <= op;
                off_q    <= addr[1:0];
                misalign <= bad_align;
                if (!bad_align) begin
                    mem_addr <= addr[ADDR_W-1:2];
                    if (op_store) mem_din <= wdata;
                end
            end
            if (state == RD) begin
                if (op_q_store) mem_din <= merge_val;
                else            rdata   <= load_val;
            end
            if (state == DONE) misalign <= 1'b0;
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mem_we    = (state == WR);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed scoreboard bench for mem_lsu: a driver pushes expected completions,
// a negedge monitor pops them on every done and compares.
module tb_mem_lsu;

    localparam int ADDR_W = 12;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    logic              clk;
    logic              reset;
    logic              req;
    logic [2:0]        op;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic              misalign;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_din;
    logic              mem_we;
    logic [31:0]       mem_dout;
    logic [1:0]        dbg_state;

    mem_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .misalign(misalign),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout), .dbg_state(dbg_state)
    );

    // ---------------- clock / memory model ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem [0:(1<<(ADDR_W-2))-1];
    assign mem_dout = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  lat;
        logic [1:0]  we;
        logic [31:0] acc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          neg_cnt = 0;
    int          we_cnt = 0;
    logic [31:0] exp_last = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        neg_cnt = neg_cnt + 1;
        if (reset) we_cnt = 0;
        else if (mem_we) we_cnt = we_cnt + 1;
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rdata", rdata, mon_e.rdata);
                chk("misalign", {31'd0, misalign}, {31'd0, mon_e.mis});
                chk("done_latency", neg_cnt - mon_e.acc, {28'd0, mon_e.lat});
                chk("we_cycles", we_cnt, {30'd0, mon_e.we});
            end
            we_cnt = 0;
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_mis, input int lat,
                         input int we, input bit hold);
        exp_t e;
        int n;
        @(negedge clk);
        op = o; addr = a; wdata = d; req = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        e.rdata = exp_rd;
        e.mis   = exp_mis;
        e.lat   = 4'(lat);
        e.we    = 2'(we);
        e.acc   = neg_cnt;
        exp_q.push_back(e);
        if (!hold) req = 1'b0;
    endtask

    task automatic ld(input logic [2:0] o, input logic [31:0] a, input logic [31:0] val,
                      input logic mis, input int lat, input bit hold);
        if (!mis) exp_last = val;
        do_op(o, a, 32'h0, exp_last, mis, lat, 0, hold);
    endtask

    task automatic st(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                      input logic mis, input int lat, input int we, input bit hold);
        do_op(o, a, d, exp_last, mis, lat, we, hold);
    endtask

    task automatic drain();
        int n;
        req = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("missing_done", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < (1 << (ADDR_W - 2)); i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABB;
        mem[8] = 32'hFFFFFFFF;
        reset = 1'b1; req = 1'b0; op = 3'b000; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        reset = 1'b0;

        // Sub-word loads from 0x8899AABB
        ld(OP_LB,  32'h11, 32'hFFFFFFAA, 1'b0, 2, 1'b0);
        ld(OP_LBU, 32'h11, 32'h000000AA, 1'b0, 2, 1'b0);
        ld(OP_LH,  32'h12, 32'hFFFF8899, 1'b0, 2, 1'b0);
        ld(OP_LHU, 32'h12, 32'h00008899, 1'b0, 2, 1'b0);

        // Byte store into lane 3
        st(OP_SB, 32'h13, 32'h0000005C, 1'b0, 3, 1, 1'b0);
        drain();
        chk("mem_after_sb", mem[4], 32'h5C99AABB);

        // Back-to-back with req held high
        st(OP_SH, 32'h20, 32'h00001234, 1'b0, 3, 1, 1'b1);
        st(OP_SW, 32'h24, 32'hDEADBEEF, 1'b0, 2, 1, 1'b1);
        ld(OP_LW, 32'h20, 32'hFFFF1234, 1'b0, 2, 1'b1);
        ld(OP_LW, 32'h24, 32'hDEADBEEF, 1'b0, 2, 1'b0);
        drain();
        chk("mem_after_sh", mem[8], 32'hFFFF1234);
        chk("mem_after_sw", mem[9], 32'hDEADBEEF);

        // Reset during the write phase of an sb
        @(negedge clk);
        op = OP_SB; addr = 32'h11; wdata = 32'h00000077; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        chk("rmw_busy_rd", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("rmw_we_in_wr", {31'd0, mem_we}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_last = 32'h0;
        chk("mem_after_rst", mem[4], 32'h5C99AABB);

        // Alignment handling
        ld(OP_LB, 32'h10, 32'hFFFFFFBB, 1'b0, 2, 1'b0);
`ifdef LSU_ALIGN_CHECK_EN
        ld(OP_LW, 32'h22, 32'h0, 1'b1, 1, 1'b0);
        ld(OP_LH, 32'h13, 32'h0, 1'b1, 1, 1'b0);
        st(OP_SH, 32'h21, 32'h0000AAAA, 1'b1, 1, 0, 1'b0);
        drain();
        chk("mem_misaligned_sh", mem[8], 32'hFFFF1234);
`else
        ld(OP_LW, 32'h22, 32'hFFFF1234, 1'b0, 2, 1'b0);
        ld(OP_LH, 32'h13, 32'h00005C99, 1'b0, 2, 1'b0);
        st(OP_SH, 32'h21, 32'h0000AAAA, 1'b0, 3, 1, 1'b0);
        drain();
        chk("mem_truncated_sh", mem[8], 32'hFFFFAAAA);
`endif
        repeat (4) @(negedge clk);
        chk("idle_at_end", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
